// File: rtl/hm74_pkg.sv
// Shared types and parity tap masks for the HM74 Hamming(7,4) transmit scheduler.
package hm74_pkg;

    typedef logic [6:0] hm74_cw_t;

    typedef enum logic [1:0] {StIdle, StLo, StHi, StGap} hm74_state_e;

    // Each mask selects the nibble bits {d3,d2,d1,d0} folded into one parity bit.
    localparam logic [3:0] Hm74P0Taps = 4'b1101;
    localparam logic [3:0] Hm74P1Taps = 4'b1011;
    localparam logic [3:0] Hm74P2Taps = 4'b0111;

endpackage

// File: rtl/hm74_encode.sv
// Combinational Hamming(7,4) encoder: codeword = {p0,p1,d3,p2,d2,d1,d0}.
module hm74_encode
    import hm74_pkg::*;
(
    input  logic [3:0] data_i,
    output hm74_cw_t   cw_o
);

    logic p0, p1, p2;

    always_comb begin
        p0   = ^(data_i & Hm74P0Taps);
        p1   = ^(data_i & Hm74P1Taps);
        p2   = ^(data_i & Hm74P2Taps);
        cw_o = {p0, p1, data_i[3], p2, data_i[2:0]};
    end

endmodule

// File: rtl/hm74_tx_sched.sv
// Two-requester round-robin byte scheduler emitting each byte as two Hamming(7,4) codewords.
// Optional LO-codeword error injection is built when HM74_ERR_INJECT_EN is defined.
module hm74_tx_sched
    import hm74_pkg::*;
#(
    parameter int unsigned IDLE_GAP = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       cw_valid,
    output logic [6:0] cw_data,
    output logic       cw_src,
    output logic       cw_last,
    input  logic       cw_ready,
`ifdef HM74_ERR_INJECT_EN
    input  logic       inj_en,
    input  logic [2:0] inj_pos,
`endif
    output logic       busy
);

    localparam logic [3:0] GapLoad = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;

    hm74_state_e state_q;
    logic        last_grant_q;
    logic        src_q;
    logic [7:0]  byte_q;
    logic [3:0]  gap_cnt_q;

    logic        idle;
    logic        grant;
    logic        accept;
    logic [3:0]  nibble;
    hm74_cw_t    enc_cw;
    hm74_cw_t    cw_mask;

    always_comb begin
        idle       = (state_q == StIdle) && !rst;
        // On a tie the requester not served last wins; otherwise the lone valid one.
        grant      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        req0_ready = idle && req0_valid && !grant;
        req1_ready = idle && req1_valid && grant;
        accept     = req0_ready || req1_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            src_q        <= 1'b0;
            byte_q       <= '0;
            gap_cnt_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        src_q        <= grant;
                        byte_q       <= grant ? req1_data : req0_data;
                        last_grant_q <= grant;
                        state_q      <= StLo;
                    end
                end
                StLo: begin
                    if (cw_ready) state_q <= StHi;
                end
                StHi: begin
                    if (cw_ready) begin
                        if (IDLE_GAP > 0) begin
                            state_q   <= StGap;
                            gap_cnt_q <= GapLoad;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StGap: begin
                    if (gap_cnt_q == 4'd0) state_q <= StIdle;
                    else gap_cnt_q <= gap_cnt_q - 4'd1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef HM74_ERR_INJECT_EN
    logic       inj_en_q;
    logic [2:0] inj_pos_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            inj_en_q  <= 1'b0;
            inj_pos_q <= '0;
        end else if (accept) begin
            inj_en_q  <= inj_en;
            inj_pos_q <= inj_pos;
        end
    end

    // Position 7 lies outside the codeword, so it leaves the LO codeword clean.
    assign cw_mask = (inj_en_q && (inj_pos_q != 3'd7) && (state_q == StLo)) ?
                     hm74_cw_t'(7'd1 << inj_pos_q) : '0;
`else
    assign cw_mask = '0;
`endif

    assign nibble = (state_q == StHi) ? byte_q[7:4] : byte_q[3:0];

    hm74_encode u_encode (
        .data_i (nibble),
        .cw_o   (enc_cw)
    );

    always_comb begin
        cw_valid = !rst && ((state_q == StLo) || (state_q == StHi));
        cw_data  = cw_valid ? (enc_cw ^ cw_mask) : '0;
        cw_src   = cw_valid && src_q;
        cw_last  = cw_valid && (state_q == StHi);
        busy     = !rst && (state_q != StIdle);
    end

endmodule

// File: tb/tb_hm74_tx_sched.sv
// Self-checking bench for hm74_tx_sched: directed cases plus a randomized phase against a
// transaction-level scoreboard. Instance u_gap runs with IDLE_GAP=3 on the same inputs.
module tb_hm74_tx_sched;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, v0, v1, cwr;
    logic [7:0] d0, d1;
    logic       r0, r1, cwv, cws, cwl, busy;
    logic [6:0] cwd;
    logic       b_r0, b_r1, b_cwv, b_cws, b_cwl, b_busy;
    logic [6:0] b_cwd;
`ifdef HM74_ERR_INJECT_EN
    logic       inj_en;
    logic [2:0] inj_pos;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [6:0] data;
        logic       src;
        logic       last;
    } cw_exp_t;

    cw_exp_t exp_q[$];
    logic    last_grant;

    hm74_tx_sched #(.IDLE_GAP(0)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (v0),
        .req0_data  (d0),
        .req0_ready (r0),
        .req1_valid (v1),
        .req1_data  (d1),
        .req1_ready (r1),
        .cw_valid   (cwv),
        .cw_data    (cwd),
        .cw_src     (cws),
        .cw_last    (cwl),
        .cw_ready   (cwr),
`ifdef HM74_ERR_INJECT_EN
        .inj_en     (inj_en),
        .inj_pos    (inj_pos),
`endif
        .busy       (busy)
    );

    hm74_tx_sched #(.IDLE_GAP(3)) u_gap (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (v0),
        .req0_data  (d0),
        .req0_ready (b_r0),
        .req1_valid (v1),
        .req1_data  (d1),
        .req1_ready (b_r1),
        .cw_valid   (b_cwv),
        .cw_data    (b_cwd),
        .cw_src     (b_cws),
        .cw_last    (b_cwl),
        .cw_ready   (cwr),
`ifdef HM74_ERR_INJECT_EN
        .inj_en     (inj_en),
        .inj_pos    (inj_pos),
`endif
        .busy       (b_busy)
    );

    // Reference encoder straight from the parity equations, in integer arithmetic.
    function automatic int enc(input int n);
        int b0, b1, b2, b3;
        b0 = n % 2;
        b1 = (n / 2) % 2;
        b2 = (n / 4) % 2;
        b3 = (n / 8) % 2;
        return ((b3 + b2 + b0) % 2) * 64 + ((b3 + b1 + b0) % 2) * 32 + b3 * 16 +
               ((b2 + b1 + b0) % 2) * 8 + b2 * 4 + b1 * 2 + b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Observe one cycle of u_dut handshakes against the scoreboard, then move to next negedge.
    task automatic step();
        logic    s, exp_grant;
        logic [7:0] b;
        int      lo, hi;
        cw_exp_t e;
        #1;
        check("ready_exclusive", r0 & r1, 0);
        if (!cwv) check("cw_data_zero_when_invalid", cwd, 0);
        if (rst) begin
            exp_q.delete();
            last_grant = 1'b1;
        end else begin
            if ((v0 && r0) || (v1 && r1)) begin
                s         = v1 && r1;
                exp_grant = (v0 && v1) ? !last_grant : v1;
                check("grant_choice", s, exp_grant);
                last_grant = s;
                b  = s ? d1 : d0;
                lo = enc(int'(b[3:0]));
                hi = enc(int'(b[7:4]));
`ifdef HM74_ERR_INJECT_EN
                if (inj_en && inj_pos <= 3'd6) lo = lo ^ (1 << inj_pos);
`endif
                exp_q.push_back('{7'(lo), s, 1'b0});
                exp_q.push_back('{7'(hi), s, 1'b1});
            end
            if (cwv && cwr) begin
                check("cw_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_cw_data", cwd, e.data);
                    check("sb_cw_src", cws, e.src);
                    check("sb_cw_last", cwl, e.last);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        v0  = 1'b0;
        v1  = 1'b0;
        cwr = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int         srcs[$];
        int         gaps;
        int         k;
        logic [7:0] bytes[2];
        int         exp_cw[2];

        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; cwr = 1'b0; d0 = '0; d1 = '0;
        last_grant = 1'b1;
`ifdef HM74_ERR_INJECT_EN
        inj_en = 1'b0; inj_pos = '0;
`endif
        @(negedge clk);

        // Reset: every output low even with both requesters valid.
        v0 = 1'b1; v1 = 1'b1; cwr = 1'b1;
        step();
        step();
        check("rst_req0_ready", r0, 0);
        check("rst_req1_ready", r1, 0);
        check("rst_cw_valid", cwv, 0);
        check("rst_cw_data", cwd, 0);
        check("rst_cw_src", cws, 0);
        check("rst_cw_last", cwl, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
        #1;
        check("post_rst_busy", busy, 0);
        @(negedge clk);

        // 0xA5 from req0.
        do_reset();
        v0 = 1'b1; d0 = 8'hA5; cwr = 1'b1;
        #1;
        check("a5_ready", r0, 1);
        step();
        v0 = 1'b0;
        check("a5_lo_valid", cwv, 1);
        check("a5_lo_data", cwd, 7'h25);
        check("a5_lo_last", cwl, 0);
        check("a5_lo_src", cws, 0);
        step();
        check("a5_hi_data", cwd, 7'h5A);
        check("a5_hi_last", cwl, 1);
        check("a5_hi_src", cws, 0);
        step();
        check("a5_done_busy", busy, 0);

        // All-zero and all-one bytes, from req0 and req1 respectively.
        bytes[0] = 8'h00; exp_cw[0] = 'h00;
        bytes[1] = 8'hFF; exp_cw[1] = 'h7F;
        for (int i = 0; i < 2; i++) begin
            do_reset();
            cwr = 1'b1;
            if (i == 0) begin v0 = 1'b1; d0 = bytes[i]; end
            else begin v1 = 1'b1; d1 = bytes[i]; end
            step();
            v0 = 1'b0; v1 = 1'b0;
            check($sformatf("edge%0d_lo_data", i), cwd, exp_cw[i]);
            check($sformatf("edge%0d_lo_src", i), cws, i);
            step();
            check($sformatf("edge%0d_hi_data", i), cwd, exp_cw[i]);
            step();
        end

        // Both valid continuously: alternating grants at one byte per 3 cycles.
        do_reset();
        v0 = 1'b1; v1 = 1'b1; d0 = 8'h11; d1 = 8'h22; cwr = 1'b1;
        for (int i = 0; i < 15; i++) begin
            #1;
            if (r0 || r1) srcs.push_back(int'(r1));
            step();
        end
        check("rr_grant_count", srcs.size(), 5);
        for (int i = 0; i < srcs.size(); i++) check($sformatf("rr_grant%0d", i), srcs[i], i % 2);
        v0 = 1'b0; v1 = 1'b0;

        // Backpressure in LO for 5 cycles.
        do_reset();
        v1 = 1'b1; d1 = 8'h3C; cwr = 1'b0;
        #1;
        check("bp_ready", r1, 1);
        step();
        v1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_hold_valid%0d", i), cwv, 1);
            check($sformatf("bp_hold_data%0d", i), cwd, enc(4'hC));
            check($sformatf("bp_hold_src%0d", i), cws, 1);
            check($sformatf("bp_hold_last%0d", i), cwl, 0);
            step();
        end
        cwr = 1'b1;
        step();
        check("bp_hi_last", cwl, 1);
        check("bp_hi_data", cwd, enc(4'h3));
        check("bp_hi_src", cws, 1);
        step();
        check("bp_done_busy", busy, 0);

        // IDLE_GAP=3 instance: count idle-but-busy cycles after HI.
        do_reset();
        v0 = 1'b1; d0 = 8'h5B; cwr = 1'b1;
        #1;
        check("gap_first_ready", b_r0, 1);
        step();
        check("gap_lo_valid", b_cwv, 1);
        check("gap_lo_last", b_cwl, 0);
        step();
        check("gap_hi_last", b_cwl, 1);
        step();
        gaps = 0;
        k = 0;
        while (!b_r0 && k < 20) begin
            if (b_busy && !b_cwv) gaps++;
            k++;
            step();
        end
        check("gap_cycles", gaps, 3);
        check("gap_resume_ready", b_r0, 1);
        v0 = 1'b0;

        // Reset while in HI drops the byte.
        do_reset();
        v0 = 1'b1; d0 = 8'h96; cwr = 1'b1;
        step();
        v0 = 1'b0;
        step();
        check("rsthi_in_hi", cwl, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rsthi_busy", busy, 0);
        check("rsthi_valid", cwv, 0);
        check("rsthi_last", cwl, 0);
        step();
        check("rsthi_valid_later", cwv, 0);
        check("rsthi_last_later", cwl, 0);

`ifdef HM74_ERR_INJECT_EN
        do_reset();
        v0 = 1'b1; d0 = 8'hA5; cwr = 1'b1; inj_en = 1'b1; inj_pos = 3'd2;
        step();
        v0 = 1'b0; inj_en = 1'b0;
        check("inj_lo_data", cwd, 7'h21);
        step();
        check("inj_hi_data", cwd, 7'h5A);
        step();
        v0 = 1'b1; inj_en = 1'b1; inj_pos = 3'd7;
        step();
        v0 = 1'b0; inj_en = 1'b0;
        check("inj7_lo_data", cwd, 7'h25);
        step();
        step();
`endif

        // Randomized traffic against the scoreboard.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            v0  = 1'($urandom_range(0, 1));
            v1  = 1'($urandom_range(0, 1));
            d0  = 8'($urandom);
            d1  = 8'($urandom);
            cwr = ($urandom_range(0, 3) != 0);
`ifdef HM74_ERR_INJECT_EN
            inj_en  = 1'($urandom_range(0, 1));
            inj_pos = 3'($urandom);
`endif
            step();
        end
        v0 = 1'b0; v1 = 1'b0; cwr = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
